// File: rtl/check_ram_writer.sv
// Purpose : write-side companion to the TLB check RAM; formats entry words and runs full-RAM flush sweeps.
// Latency : a request accepted in cycle N is written in cycle N+1; a flush takes 2^RAM_AW write cycles.
// Backpressure: cfg_ready_o drops while a write or flush is outstanding; search_busy_i stalls every RAM write.
// Optional: define CHECK_RAM_WRITER_STATS_EN to build the 16-bit search-stall counter on stall_cnt_o.
module check_ram_writer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int PAGE_SIZE    = 4096,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                cfg_valid_i,
  output logic                                cfg_ready_o,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]     cfg_idx_i,
  input  logic [ADDR_WIDTH-1:0]               cfg_vaddr_i,
  input  logic [3:0]                          cfg_flags_i,
  input  logic                                flush_req_i,
  output logic                                flush_busy_o,
  input  logic                                search_busy_i,
  output logic                                ram_we_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     ram_waddr_o,
  output logic [31:0]                         ram_wdata_o,
  output logic                                wr_done_o,
  output logic [15:0]                         stall_cnt_o
);

  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int RAM_AW     = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam int VPN_W      = ADDR_WIDTH - IGNORE_LSB;

  // The entry word only has room for 28 VPN bits above the 4 flag bits.
  if (VPN_W > 28) begin : g_vpn_width_check
    $error("check_ram_writer: VPN width exceeds 28 bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic                flush_pend_q;
  logic [RAM_AW-1:0]   flush_cnt_q;
  logic [RAM_AW-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         entry_word;
  logic                busy_state;
  logic                unused_vaddr_lsb;

  // Page-offset bits of the virtual address are not stored.
  assign unused_vaddr_lsb = ^cfg_vaddr_i[IGNORE_LSB-1:0];

  // Format the incoming request into the 32-bit entry layout: flags low, VPN above, zeros on top.
  always_comb begin
    entry_word               = '0;
    entry_word[3:0]          = cfg_flags_i;
    entry_word[4 +: VPN_W]   = cfg_vaddr_i[ADDR_WIDTH-1:IGNORE_LSB];
  end

  // Control FSM: IDLE accepts requests (flush first), WRITE commits one entry, FLUSH sweeps every address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_pend_q || flush_req_i) begin
            // The pending request is consumed on entry so a new pulse during the sweep can queue another one.
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
          end else if (cfg_valid_i) begin
            idx_q   <= cfg_idx_i;
            wdata_q <= entry_word;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (flush_req_i) begin
            flush_pend_q <= 1'b1;
          end
          if (!search_busy_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_req_i) begin
            flush_pend_q <= 1'b1;
          end
          if (!search_busy_i) begin
            flush_cnt_q <= flush_cnt_q + RAM_AW'(1);
            if (flush_cnt_q == '1) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_state = (state_q == ST_WRITE) || (state_q == ST_FLUSH);

  // A write fires only in a cycle with no search; the bus is forced to zero otherwise.
  always_comb begin
    ram_we_o    = busy_state && !search_busy_i;
    wr_done_o   = (state_q == ST_WRITE) && !search_busy_i;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    if (ram_we_o) begin
      if (state_q == ST_WRITE) begin
        ram_waddr_o = idx_q;
        ram_wdata_o = wdata_q;
      end else begin
        ram_waddr_o = flush_cnt_q;
      end
    end
  end

  assign cfg_ready_o  = (state_q == ST_IDLE) && !flush_pend_q && !flush_req_i;
  assign flush_busy_o = flush_pend_q || (state_q == ST_FLUSH);

`ifdef CHECK_RAM_WRITER_STATS_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where an outstanding write or flush is held off by a search; saturate at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (busy_state && search_busy_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_check_ram_writer.sv
// Bench for check_ram_writer: directed stimulus, write expectations queued, monitor compares each RAM write.
module tb_check_ram_writer;

  localparam int RAM_AW = 10;
`ifdef CHECK_RAM_WRITER_STATS_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  typedef struct {
    logic [RAM_AW-1:0] addr;
    logic [31:0]       data;
    logic              cfg;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [RAM_AW-1:0] cfg_idx_i;
  logic [31:0]       cfg_vaddr_i;
  logic [3:0]        cfg_flags_i;
  logic              flush_req_i;
  logic              flush_busy_o;
  logic              search_busy_i;
  logic              ram_we_o;
  logic [RAM_AW-1:0] ram_waddr_o;
  logic [31:0]       ram_wdata_o;
  logic              wr_done_o;
  logic [15:0]       stall_cnt_o;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  check_ram_writer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_idx_i     (cfg_idx_i),
    .cfg_vaddr_i   (cfg_vaddr_i),
    .cfg_flags_i   (cfg_flags_i),
    .flush_req_i   (flush_req_i),
    .flush_busy_o  (flush_busy_o),
    .search_busy_i (search_busy_i),
    .ram_we_o      (ram_we_o),
    .ram_waddr_o   (ram_waddr_o),
    .ram_wdata_o   (ram_wdata_o),
    .wr_done_o     (wr_done_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [RAM_AW-1:0] a, input logic [31:0] d, input logic c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cfg  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_flush(input int n);
    for (int i = 0; i < n; i++) push_exp(RAM_AW'(i), 32'h0, 1'b0);
  endtask

  // Monitor: every RAM write must match the head of the expectation queue; idle bus must be zero.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (ram_we_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=no write", ram_waddr_o, ram_wdata_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(ram_waddr_o), 32'(e.addr));
            chk("wr_data", ram_wdata_o, e.data);
            chk("wr_done", 32'(wr_done_o), 32'(e.cfg));
          end
        end else begin
          chk("idle_bus_zero", 32'((ram_waddr_o != '0) || (ram_wdata_o != '0) || wr_done_o), 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    int bad;
    rst_ni        = 1'b0;
    cfg_valid_i   = 1'b0;
    cfg_idx_i     = '0;
    cfg_vaddr_i   = '0;
    cfg_flags_i   = '0;
    flush_req_i   = 1'b0;
    search_busy_i = 1'b0;
    #3;
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'h1);
    chk("rst_ram_we", 32'(ram_we_o), 32'h0);
    chk("rst_flush_busy", 32'(flush_busy_o), 32'h0);
    chk("rst_bus", 32'((ram_waddr_o != '0) || (ram_wdata_o != '0) || wr_done_o), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
    step();
    step();
    rst_ni = 1'b1;

    // Plain write, no search.
    step();
    cfg_valid_i = 1'b1; cfg_idx_i = 10'h015; cfg_vaddr_i = 32'h1234_5678; cfg_flags_i = 4'b0111;
    push_exp(10'h015, 32'h0012_3457, 1'b1);
    @(negedge clk_i);
    chk("w1_accept", 32'(cfg_ready_o), 32'h1);
    step();
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("w1_we_next_cycle", 32'(ram_we_o), 32'h1);
    chk("w1_ready_low", 32'(cfg_ready_o), 32'h0);

    // Same write held off by three search cycles.
    step();
    cfg_valid_i = 1'b1;
    push_exp(10'h015, 32'h0012_3457, 1'b1);
    @(negedge clk_i);
    chk("w2_accept", 32'(cfg_ready_o), 32'h1);
    step();
    cfg_valid_i = 1'b0; search_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk_i);
      chk("w2_stalled_we", 32'(ram_we_o), 32'h0);
    end
    step();
    search_busy_i = 1'b0;
    @(negedge clk_i);
    chk("w2_we_after_stall", 32'(ram_we_o), 32'h1);
    chk("w2_stall_cnt", 32'(stall_cnt_o), 32'(EXP_STALL));

    // Flush pulse in IDLE: 1024 back-to-back zero writes.
    step();
    flush_req_i = 1'b1;
    push_flush(1024);
    @(negedge clk_i);
    chk("fl_pulse_ready_low", 32'(cfg_ready_o), 32'h0);
    bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      step();
      flush_req_i = 1'b0;
      @(negedge clk_i);
      if (!ram_we_o || !flush_busy_o || cfg_ready_o) bad++;
    end
    chk("fl_sweep_bad_cycles", 32'(bad), 32'h0);
    step();
    @(negedge clk_i);
    chk("fl_done_busy", 32'(flush_busy_o), 32'h0);
    chk("fl_done_ready", 32'(cfg_ready_o), 32'h1);
    chk("fl_done_we", 32'(ram_we_o), 32'h0);

    // Flush and request together: flush wins, request taken in first IDLE cycle afterwards.
    step();
    flush_req_i = 1'b1; cfg_valid_i = 1'b1;
    cfg_idx_i = 10'h02A; cfg_vaddr_i = 32'hABCD_E000; cfg_flags_i = 4'b1110;
    push_flush(1024);
    push_exp(10'h02A, 32'h00AB_CDEE, 1'b1);
    @(negedge clk_i);
    chk("fc_ready_low", 32'(cfg_ready_o), 32'h0);
    k = 0;
    for (int i = 1; i <= 1200; i++) begin
      step();
      flush_req_i = 1'b0;
      @(negedge clk_i);
      if (cfg_ready_o) begin
        k = i;
        break;
      end
    end
    chk("fc_accept_cycle", 32'(k), 32'd1025);
    step();
    cfg_valid_i = 1'b0;

    // All-ones VPN at the top index, then a flush during WRITE and a repeat during the sweep.
    step();
    cfg_valid_i = 1'b1; cfg_idx_i = 10'h3FF; cfg_vaddr_i = 32'hFFFF_FFFF; cfg_flags_i = 4'b1001;
    push_exp(10'h3FF, 32'h00FF_FFF9, 1'b1);
    push_flush(2048);
    @(negedge clk_i);
    chk("mx_accept", 32'(cfg_ready_o), 32'h1);
    step();
    cfg_valid_i = 1'b0; search_busy_i = 1'b1; flush_req_i = 1'b1;
    @(negedge clk_i);
    chk("mx_held_we", 32'(ram_we_o), 32'h0);
    step();
    search_busy_i = 1'b0; flush_req_i = 1'b0;
    @(negedge clk_i);
    chk("mx_write_we", 32'(ram_we_o), 32'h1);
    chk("mx_pend_busy", 32'(flush_busy_o), 32'h1);
    k = 0;
    for (int i = 1; i <= 3000; i++) begin
      step();
      flush_req_i = (i == 10);
      @(negedge clk_i);
      if (!flush_busy_o) begin
        k = i;
        break;
      end
    end
    flush_req_i = 1'b0;
    chk("mx_two_sweeps_cycles", 32'(k), 32'd2051);
    chk("mx_queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset while the flush is presenting address 500.
    step();
    flush_req_i = 1'b1;
    push_flush(500);
    step();
    flush_req_i = 1'b0;
    repeat (499) step();
    step();
    chk("rs_at_addr_500", 32'(ram_waddr_o), 32'd500);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rs_we_async", 32'(ram_we_o), 32'h0);
    chk("rs_bus_async", 32'((ram_waddr_o != '0) || (ram_wdata_o != '0) || wr_done_o), 32'h0);
    chk("rs_busy_async", 32'(flush_busy_o), 32'h0);
    chk("rs_ready_async", 32'(cfg_ready_o), 32'h1);
    chk("rs_stall_cnt", 32'(stall_cnt_o), 32'h0);
    step();
    step();
    rst_ni = 1'b1;
    repeat (20) step();
    @(negedge clk_i);
    chk("rs_post_ready", 32'(cfg_ready_o), 32'h1);
    chk("rs_post_busy", 32'(flush_busy_o), 32'h0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
